// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID register, stall buffer and redirect drain
// Keeps one imem request in flight; a redirect during an unacknowledged fetch waits in DRAIN for that response.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [5:0]  id_opcode,
  output logic [5:0]  id_funct
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] target_q, target_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    target_d    = target_q;
    id_valid_d  = id_valid_q;
    id_pc_d     = id_pc_q;
    id_instr_d  = id_instr_q;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          id_valid_d = 1'b0;
          if (imem_ack) begin
            pc_d = redirect_tgt;
          end else begin
            target_d = redirect_tgt;
            state_d  = DRAIN;
          end
        end else if (stall) begin
          if (imem_ack) begin
            buf_pc_d    = pc_q;
            buf_instr_d = imem_rdata;
            state_d     = HOLD;
          end
        end else if (imem_ack) begin
          id_valid_d = 1'b1;
          id_pc_d    = pc_q;
          id_instr_d = imem_rdata;
          pc_d       = pc_q + 32'd4;
        end else begin
          id_valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          id_valid_d = 1'b0;
          pc_d       = redirect_tgt;
          state_d    = FETCH;
        end else if (!stall) begin
          id_valid_d = 1'b1;
          id_pc_d    = buf_pc_q;
          id_instr_d = buf_instr_q;
          pc_d       = buf_pc_q + 32'd4;
          state_d    = FETCH;
        end
      end
      DRAIN: begin
        // The outstanding response is thrown away; the latest target wins.
        id_valid_d = 1'b0;
        if (redirect) begin
          if (imem_ack) begin
            pc_d    = redirect_tgt;
            state_d = FETCH;
          end else begin
            target_d = redirect_tgt;
          end
        end else if (imem_ack) begin
          pc_d    = target_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      buf_pc_q    <= 32'd0;
      buf_instr_q <= 32'd0;
      target_q    <= 32'd0;
      id_valid_q  <= 1'b0;
      id_pc_q     <= 32'd0;
      id_instr_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      target_q    <= target_d;
      id_valid_q  <= id_valid_d;
      id_pc_q     <= id_pc_d;
      id_instr_q  <= id_instr_d;
    end
  end

  assign imem_req  = (state_q != HOLD) && !rst;
  assign imem_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign id_instr  = id_instr_q;
  assign id_opcode = id_instr_q[31:26];
  assign id_funct  = id_instr_q[5:0];

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed vector table plus randomized run against a flag-based fetch model
module tb_if_stage;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, imem_ack;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, id_valid;
  logic [31:0] imem_addr, id_pc, id_instr;
  logic [5:0]  id_opcode, id_funct;

  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .id_opcode(id_opcode), .id_funct(id_funct)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  typedef struct {
    bit          stall;
    bit          redirect;
    bit          ack;
    logic [31:0] rpc;
    bit          v;
    logic [31:0] idpc;
    bit          req;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[19];

  // Model state: a pending stall buffer and a pending redirect target, as plain flags.
  bit          m_hold, m_drain, m_v;
  logic [31:0] m_pc, m_tgt, m_hpc, m_hinstr, m_idpc, m_idinstr;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input bit v, input logic [31:0] pc,
                         input logic [31:0] instr, input bit req, input logic [31:0] addr);
    chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, v});
    chk({tag, ".id_pc"}, id_pc, pc);
    chk({tag, ".id_instr"}, id_instr, instr);
    chk({tag, ".id_opcode"}, {26'd0, id_opcode}, {26'd0, instr[31:26]});
    chk({tag, ".id_funct"}, {26'd0, id_funct}, {26'd0, instr[5:0]});
    chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, req});
    chk({tag, ".imem_addr"}, imem_addr, addr);
  endtask

  task automatic model_reset();
    m_hold = 0; m_drain = 0; m_v = 0;
    m_pc = 32'd0; m_tgt = 32'd0; m_hpc = 32'd0; m_hinstr = 32'd0;
    m_idpc = 32'd0; m_idinstr = 32'd0;
  endtask

  task automatic model_step(input bit s, input bit r, input logic [31:0] rpc,
                            input bit a, input logic [31:0] rd);
    logic [31:0] t;
    t = {rpc[31:2], 2'b00};
    if (r) begin
      m_v = 0;
      if (m_hold || a) begin
        m_pc = t; m_hold = 0; m_drain = 0;
      end else begin
        m_drain = 1; m_tgt = t;
      end
    end else if (m_drain) begin
      if (a) begin m_pc = m_tgt; m_drain = 0; end
    end else if (m_hold) begin
      if (!s) begin
        m_v = 1; m_idpc = m_hpc; m_idinstr = m_hinstr; m_pc = m_hpc + 4; m_hold = 0;
      end
    end else if (a) begin
      if (s) begin
        m_hold = 1; m_hpc = m_pc; m_hinstr = rd;
      end else begin
        m_v = 1; m_idpc = m_pc; m_idinstr = rd; m_pc = m_pc + 4;
      end
    end else if (!s) begin
      m_v = 0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] cur_addr;
    bit s, r, a;
    logic [31:0] rpc, rd;

    // stall, redirect, ack, redirect_pc | id_valid, id_pc, imem_req, imem_addr
    tbl[0]  = '{0, 0, 1, 32'h0,        1, 32'h0,        1, 32'h4};
    tbl[1]  = '{1, 0, 1, 32'h0,        1, 32'h0,        0, 32'h4};
    tbl[2]  = '{1, 0, 0, 32'h0,        1, 32'h0,        0, 32'h4};
    tbl[3]  = '{1, 0, 0, 32'h0,        1, 32'h0,        0, 32'h4};
    tbl[4]  = '{0, 0, 0, 32'h0,        1, 32'h4,        1, 32'h8};
    tbl[5]  = '{0, 0, 0, 32'h0,        0, 32'h4,        1, 32'h8};
    tbl[6]  = '{0, 1, 0, 32'h103,      0, 32'h4,        1, 32'h8};
    tbl[7]  = '{0, 0, 0, 32'h0,        0, 32'h4,        1, 32'h8};
    tbl[8]  = '{1, 1, 0, 32'h200,      0, 32'h4,        1, 32'h8};
    tbl[9]  = '{0, 0, 1, 32'h0,        0, 32'h4,        1, 32'h200};
    tbl[10] = '{0, 0, 1, 32'h0,        1, 32'h200,      1, 32'h204};
    tbl[11] = '{1, 0, 1, 32'h0,        1, 32'h200,      0, 32'h204};
    tbl[12] = '{1, 1, 0, 32'hFFFF_FFFF, 0, 32'h200,     1, 32'hFFFF_FFFC};
    tbl[13] = '{0, 0, 1, 32'h0,        1, 32'hFFFF_FFFC, 1, 32'h0};
    tbl[14] = '{0, 0, 1, 32'h0,        1, 32'h0,        1, 32'h4};
    tbl[15] = '{0, 1, 1, 32'h40,       0, 32'h0,        1, 32'h40};
    tbl[16] = '{0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h40};
    tbl[17] = '{1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h40};
    tbl[18] = '{0, 0, 1, 32'h0,        1, 32'h40,       1, 32'h44};

    rst = 1; stall = 0; redirect = 0; redirect_pc = 0; imem_ack = 0; imem_rdata = 0;
    #12;
    chk_all("reset", 0, 32'h0, 32'h0, 0, 32'h0);
    rst = 0;

    cur_addr = 32'h0;
    for (int i = 0; i < 19; i++) begin
      stall = tbl[i].stall; redirect = tbl[i].redirect; redirect_pc = tbl[i].rpc;
      imem_ack = tbl[i].ack; imem_rdata = cur_addr ^ K;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), tbl[i].v, tbl[i].idpc, tbl[i].idpc ^ K, tbl[i].req, tbl[i].addr);
      cur_addr = tbl[i].addr;
    end

    // Enter DRAIN, then reset between edges.
    stall = 0; redirect = 1; redirect_pc = 32'h80; imem_ack = 0;
    @(posedge clk); #1;
    chk_all("drain", 0, 32'h40, 32'h40 ^ K, 1, 32'h44);
    redirect = 0;
    #2 rst = 1;
    #1 chk_all("async_rst", 0, 32'h0, 32'h0, 0, 32'h0);
    #1 rst = 0;
    #1 chk_all("post_rst", 0, 32'h0, 32'h0, 1, 32'h0);
    imem_ack = 1; imem_rdata = 32'h0 ^ K;
    @(posedge clk); #1;
    chk_all("post_rst_fetch", 1, 32'h0, K, 1, 32'h4);

    imem_ack = 0;
    rst = 1; #1 rst = 0;
    model_reset();
    for (int n = 0; n < 2500; n++) begin
      s   = ($urandom % 4) == 0;
      r   = ($urandom % 10) == 0;
      rpc = $urandom;
      a   = !m_hold && (($urandom % 3) != 0);
      rd  = a ? mem(m_pc) : $urandom;
      stall = s; redirect = r; redirect_pc = rpc; imem_ack = a; imem_rdata = rd;
      @(posedge clk); #1;
      model_step(s, r, rpc, a, rd);
      chk_all($sformatf("rnd%0d", n), m_v, m_idpc, m_idinstr, !m_hold, m_pc);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
